// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the retire trace collector.
package trace_pkg;
   localparam int XLEN = 32;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } if_entry_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            rd_v;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } trace_rec_t;
   localparam int IF_W  = $bits(if_entry_t);
   localparam int REC_W = $bits(trace_rec_t);
   // Instructions without a register write carry zero rd/data so records compare cleanly.
   function automatic trace_rec_t mk_rec(if_entry_t e, logic rd_v, logic [4:0] rd, logic [XLEN-1:0] data);
      mk_rec = '{pc: e.pc, inst: e.inst, rd_v: rd_v, rd: rd_v ? rd : 5'd0, data: rd_v ? data : {XLEN{1'b0}}};
   endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with wrap-bit pointers; push while full succeeds only with a same-cycle pop.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wp, r_rp;
   logic             w_push, w_pop;
   assign empty  = r_wp == r_rp;
   assign full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign count  = r_wp - r_rp;
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);
   // Head is masked while empty so stale storage never reaches the consumer.
   assign dout   = empty ? '0 : r_mem[r_rp[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
      end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp[AW-1:0]] <= din;
endmodule

// File: rtl/retire_trace_buf.sv
// retire_trace_buf: pairs issued instructions with their write-back and streams retire records in order.
module retire_trace_buf
   import trace_pkg::*;
#(
   parameter int IF_DEPTH = 4,
   parameter int DEPTH    = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            iss_v,
   input  logic [XLEN-1:0] iss_pc,
   input  logic [31:0]     iss_inst,
   input  logic            ret_v,
   input  logic            ret_rd_v,
   input  logic [4:0]      ret_rd,
   input  logic [XLEN-1:0] ret_data,
   output logic            out_valid,
   input  logic            out_ready,
   output trace_rec_t      out_rec,
   output logic            stall_o,
   output logic [31:0]     n_iss,
   output logic [31:0]     n_ret,
   output logic            err_o,
   output logic            drop_o
);
   localparam int IAW = $clog2(IF_DEPTH);
   localparam int OAW = $clog2(DEPTH);
   if_entry_t   w_if_dout;
   trace_rec_t  w_rec;
   logic        w_if_full, w_if_empty, w_out_full, w_out_empty;
   logic [IAW:0] w_if_cnt, w_if_cnt_n;
   logic [OAW:0] w_out_cnt, w_out_cnt_n;
   logic        w_ret_ok, w_iss_ok, w_out_pop, w_out_ok, w_err, w_drop;
   logic [31:0] r_n_iss, r_n_ret;
   logic        r_err, r_drop, r_stall;
   // Retire only consumes entries issued in earlier cycles, so the check uses registered empty.
   assign w_ret_ok  = ret_v && !w_if_empty;
   assign w_iss_ok  = iss_v && (!w_if_full || w_ret_ok);
   assign w_out_pop = !w_out_empty && out_ready;
   assign w_out_ok  = w_ret_ok && (!w_out_full || w_out_pop);
   assign w_err     = (ret_v && w_if_empty) || (iss_v && !w_iss_ok);
   assign w_drop    = w_ret_ok && !w_out_ok;
   assign w_rec     = mk_rec(w_if_dout, ret_rd_v, ret_rd, ret_data);
   assign w_if_cnt_n  = w_if_cnt + (IAW+1)'(w_iss_ok) - (IAW+1)'(w_ret_ok);
   assign w_out_cnt_n = w_out_cnt + (OAW+1)'(w_out_ok) - (OAW+1)'(w_out_pop);
   trace_fifo #(.WIDTH(IF_W), .DEPTH(IF_DEPTH)) u_if_fifo (
      .clk(clk), .rst_n(reset), .push(iss_v), .pop(w_ret_ok),
      .din({iss_pc, iss_inst}), .dout(w_if_dout),
      .full(w_if_full), .empty(w_if_empty), .count(w_if_cnt)
   );
   trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_out_fifo (
      .clk(clk), .rst_n(reset), .push(w_ret_ok), .pop(out_ready),
      .din(w_rec), .dout(out_rec),
      .full(w_out_full), .empty(w_out_empty), .count(w_out_cnt)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_n_iss <= '0;
         r_n_ret <= '0;
         r_err   <= 1'b0;
         r_drop  <= 1'b0;
         r_stall <= 1'b0;
      end else begin
         if (iss_v) r_n_iss <= r_n_iss + 1'b1;
         if (w_ret_ok) r_n_ret <= r_n_ret + 1'b1;
         if (w_err) r_err <= 1'b1;
         if (w_drop) r_drop <= 1'b1;
         r_stall <= (w_out_cnt_n >= (OAW+1)'(DEPTH-2)) || (w_if_cnt_n >= (IAW+1)'(IF_DEPTH-1));
      end
   assign out_valid = !w_out_empty;
   assign stall_o   = r_stall;
   assign n_iss     = r_n_iss;
   assign n_ret     = r_n_ret;
   assign err_o     = r_err;
   assign drop_o    = r_drop;
endmodule

// File: tb/tb_retire_trace_buf.sv
// tb_retire_trace_buf: directed scoreboard bench for retire_trace_buf.
module tb_retire_trace_buf;
   import trace_pkg::*;
   logic        clk = 1'b0;
   logic        reset;
   logic        iss_v, ret_v, ret_rd_v, out_ready;
   logic [31:0] iss_pc, iss_inst, ret_data;
   logic [4:0]  ret_rd;
   logic        out_valid, stall_o, err_o, drop_o;
   logic [31:0] n_iss, n_ret;
   trace_rec_t  out_rec;
   int          tests = 0;
   int          fails = 0;
   logic [REC_W-1:0] q[$];
   logic [REC_W-1:0] exp_rec;

   always #5 clk = ~clk;

   retire_trace_buf #(.IF_DEPTH(4), .DEPTH(8)) dut (
      .clk(clk), .reset(reset), .iss_v(iss_v), .iss_pc(iss_pc), .iss_inst(iss_inst),
      .ret_v(ret_v), .ret_rd_v(ret_rd_v), .ret_rd(ret_rd), .ret_data(ret_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec), .stall_o(stall_o),
      .n_iss(n_iss), .n_ret(n_ret), .err_o(err_o), .drop_o(drop_o)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      if (out_valid && out_ready) begin
         chk("pop_expected", 128'(q.size() != 0), 128'd1);
         if (q.size() != 0) chk("rec_order", 128'(out_rec), 128'(q.pop_front()));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_v = 0; ret_v = 0; ret_rd_v = 0;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
      iss_v = 1; iss_pc = pc; iss_inst = inst;
   endtask

   task automatic retire(input logic rdv, input logic [4:0] rd, input logic [31:0] d,
                         input logic [31:0] pc, input logic [31:0] inst, input logic expect_rec);
      ret_v = 1; ret_rd_v = rdv; ret_rd = rd; ret_data = d;
      if (expect_rec) q.push_back({pc, inst, rdv, rdv ? rd : 5'd0, rdv ? d : 32'd0});
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 128'(out_valid), 128'd0);
      chk({tag, "_rec"}, 128'(out_rec), 128'd0);
      chk({tag, "_stall"}, 128'(stall_o), 128'd0);
      chk({tag, "_niss"}, 128'(n_iss), 128'd0);
      chk({tag, "_nret"}, 128'(n_ret), 128'd0);
      chk({tag, "_err"}, 128'(err_o), 128'd0);
      chk({tag, "_drop"}, 128'(drop_o), 128'd0);
   endtask

   initial begin
      reset = 0; out_ready = 0; iss_pc = 0; iss_inst = 0; ret_rd = 0; ret_data = 0;
      idle();
      for (int i = 0; i < 4; i++) begin
         iss_v = 1'($urandom); ret_v = 1'($urandom); ret_rd_v = 1'($urandom);
         out_ready = 1'($urandom); iss_pc = $urandom; iss_inst = $urandom;
         ret_rd = 5'($urandom); ret_data = $urandom;
         @(posedge clk); #1;
         chk_idle("in_reset");
      end
      idle(); out_ready = 0;
      reset = 1;
      cyc(); cyc();
      chk_idle("post_reset");

      // single op
      issue(32'h8000_0000, 32'h0010_0093); cyc();
      idle(); cyc();
      retire(1, 5'd1, 32'd1, 32'h8000_0000, 32'h0010_0093, 1); cyc();
      idle();
      exp_rec = {32'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 32'd1};
      chk("single_valid", 128'(out_valid), 128'd1);
      chk("single_rec", 128'(out_rec), 128'(exp_rec));
      chk("single_niss", 128'(n_iss), 128'd1);
      chk("single_nret", 128'(n_ret), 128'd1);
      out_ready = 1; cyc(); cyc();
      chk("single_drained", 128'(out_valid), 128'd0);
      out_ready = 0;

      // ordering under back-pressure, one op without a register write
      for (int k = 0; k < 8; k++) begin
         issue(32'h100 + 32'(4 * k), 32'h1000 + 32'(k)); cyc();
         idle();
         retire(k != 3, 5'(k + 1), 32'hA0 + 32'(k), 32'h100 + 32'(4 * k), 32'h1000 + 32'(k), 1); cyc();
         idle();
         chk("bp_stall", 128'(stall_o), 128'(k >= 5));
      end
      chk("bp_nodrop", 128'(drop_o), 128'd0);
      chk("bp_err", 128'(err_o), 128'd0);
      out_ready = 1;
      for (int i = 0; i < 10; i++) cyc();
      chk("bp_all_out", 128'(q.size()), 128'd0);
      chk("bp_empty", 128'(out_valid), 128'd0);
      chk("bp_stall_clear", 128'(stall_o), 128'd0);
      out_ready = 0;

      // overflow with overlapping issue/retire
      issue(32'h300, 32'h3000); cyc();
      for (int k = 0; k < 9; k++) begin
         idle();
         if (k < 8) issue(32'h300 + 32'(4 * (k + 1)), 32'h3000 + 32'(k + 1));
         retire(1, 5'(k + 2), 32'hB0 + 32'(k), 32'h300 + 32'(4 * k), 32'h3000 + 32'(k), k < 8);
         cyc();
         chk("ovf_drop", 128'(drop_o), 128'(k == 8));
      end
      idle();
      chk("ovf_nret", 128'(n_ret), 128'd18);
      chk("ovf_niss", 128'(n_iss), 128'd18);
      chk("ovf_err", 128'(err_o), 128'd0);
      out_ready = 1;
      for (int i = 0; i < 10; i++) cyc();
      chk("ovf_all_out", 128'(q.size()), 128'd0);
      chk("ovf_empty", 128'(out_valid), 128'd0);
      out_ready = 0;

      // reset mid-stream
      for (int k = 0; k < 3; k++) begin
         issue(32'h400 + 32'(4 * k), 32'h4000); cyc();
         idle();
         retire(1, 5'd3, 32'(k), 32'h400 + 32'(4 * k), 32'h4000, 1); cyc();
         idle();
      end
      chk("mid_queued", 128'(out_valid), 128'd1);
      reset = 0; #1;
      chk("mid_async", 128'(out_valid), 128'd0);
      q.delete();
      @(posedge clk); #1;
      reset = 1;
      cyc();
      chk_idle("mid_reset");

      // bad retire, then retire alongside an issue into empty
      retire(1, 5'd4, 32'h55, 0, 0, 0); cyc();
      idle();
      chk("bad_err", 128'(err_o), 128'd1);
      chk("bad_norec", 128'(out_valid), 128'd0);
      chk("bad_nret", 128'(n_ret), 128'd0);
      issue(32'h200, 32'h2000);
      retire(1, 5'd4, 32'h55, 0, 0, 0); cyc();
      idle();
      chk("same_norec", 128'(out_valid), 128'd0);
      chk("same_niss", 128'(n_iss), 128'd1);
      chk("same_nret", 128'(n_ret), 128'd0);
      retire(1, 5'd5, 32'h66, 32'h200, 32'h2000, 1); cyc();
      idle();
      chk("kept_valid", 128'(out_valid), 128'd1);
      chk("kept_nret", 128'(n_ret), 128'd1);
      out_ready = 1; cyc(); cyc();
      chk("kept_all_out", 128'(q.size()), 128'd0);
      chk("kept_err_sticky", 128'(err_o), 128'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
